serial_binary_svm: RTL

SERIAL_BINARY_SVM -- requirements
Module: serial_binary_svm

---
 rtl/svm_pkg.sv | 22 ++
 rtl/svm_mac.sv | 27 ++
 rtl/serial_binary_svm.sv | 100 ++++++++++
 3 files changed

// File: rtl/svm_pkg.sv
// rtl/svm_pkg.sv - shared types, defaults and sizing helper for the serial binary SVM
package svm_pkg;

    localparam int DEF_INPUT_WIDTH  = 4;
    localparam int DEF_WEIGHT_WIDTH = 8;
    localparam int DEF_BIAS_WIDTH   = 12;
    localparam int DEF_N_FEATURES   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } svm_state_t;

    // Accumulator wide enough that bias plus N worst-case products can never overflow
    function automatic int acc_width(input int iw, input int ww, input int bw, input int n);
        int prod_sum;
        prod_sum = iw + ww + $clog2(n) + 1;
        return (prod_sum > bw + 1) ? prod_sum : bw + 1;
    endfunction

endpackage

// File: rtl/svm_mac.sv
// rtl/svm_mac.sv - combinational signed-weight by unsigned-feature multiply-add
module svm_mac
    import svm_pkg::*;
#(
    parameter int IW = DEF_INPUT_WIDTH,
    parameter int WW = DEF_WEIGHT_WIDTH,
    parameter int AW = acc_width(DEF_INPUT_WIDTH, DEF_WEIGHT_WIDTH, DEF_BIAS_WIDTH, DEF_N_FEATURES)
) (
    input  logic [IW-1:0]        x,
    input  logic signed [WW-1:0] w,
    input  logic signed [AW-1:0] acc_in,
    output logic signed [AW-1:0] acc_out
);

    logic signed [IW:0]      x_ext;
    logic signed [IW+WW:0]   prod;
    logic signed [AW-1:0]    prod_ext;

    // Zero-extend the feature so the multiply stays signed, then sign-extend the product
    always_comb begin
        x_ext    = {1'b0, x};
        prod     = w * x_ext;
        prod_ext = {{(AW-IW-WW-1){prod[IW+WW]}}, prod};
        acc_out  = acc_in + prod_ext;
    end

endmodule

// File: rtl/serial_binary_svm.sv
// rtl/serial_binary_svm.sv - one-feature-per-cycle binary SVM decision engine
module serial_binary_svm
    import svm_pkg::*;
#(
    parameter int inputWidth  = DEF_INPUT_WIDTH,
    parameter int weightWidth = DEF_WEIGHT_WIDTH,
    parameter int biasWidth   = DEF_BIAS_WIDTH,
    parameter int N_features  = DEF_N_FEATURES
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [inputWidth*N_features-1:0]  inputs,
    input  logic [weightWidth*N_features-1:0] svmweights,
    input  logic [biasWidth-1:0]              svmbias,
    output logic                              busy,
    output logic                              ready,
    output logic                              class_o
);

    localparam int AW   = acc_width(inputWidth, weightWidth, biasWidth, N_features);
    localparam int IDXW = $clog2(N_features);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_features - 1);

    svm_state_t               state;
    logic signed [AW-1:0]     acc;
    logic signed [AW-1:0]     acc_next;
    logic signed [AW-1:0]     bias_ext;
    logic [IDXW-1:0]          idx;
    logic [inputWidth-1:0]    x_sel;
    logic signed [weightWidth-1:0] w_sel;

    // Feature/weight select driven by the running index; bias sign-extended for reload
    always_comb begin
        x_sel    = inputs[idx*inputWidth +: inputWidth];
        w_sel    = svmweights[idx*weightWidth +: weightWidth];
        bias_ext = {{(AW-biasWidth){svmbias[biasWidth-1]}}, svmbias};
    end

    svm_mac #(
        .IW (inputWidth),
        .WW (weightWidth),
        .AW (AW)
    ) u_mac (
        .x       (x_sel),
        .w       (w_sel),
        .acc_in  (acc),
        .acc_out (acc_next)
    );

    // Control FSM with registered busy/ready/class outputs; decision taken on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            idx     <= '0;
            busy    <= 1'b0;
            ready   <= 1'b0;
            class_o <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= bias_ext;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= ACC;
                    end
                end
                ACC: begin
                    acc <= acc_next;
                    if (idx == LAST_IDX) begin
                        idx     <= '0;
                        class_o <= ~acc_next[AW-1];
                        ready   <= 1'b1;
                        state   <= DONE;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                DONE: begin
                    if (start) begin
                        acc   <= bias_ext;
                        idx   <= '0;
                        state <= ACC;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
